// File: rtl/seq_fsm_pkg.sv
// Shared FSM state encoding for the serial pattern transmitter and the sequence detectors.
package seq_fsm_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle for seq_pattern_tx; master drives requests, slave is the transmitter.
interface seq_pattern_tx_if #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             x_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic [1:0]       statereg;

    modport master (
        output start, pattern, repeat_n,
        input  x_out, valid, busy, done, statereg
    );

    modport slave (
        input  start, pattern, repeat_n,
        output x_out, valid, busy, done, statereg
    );
endinterface

// File: rtl/pat_shift_reg.sv
// Loadable MSB-first shift register with a held copy of the pattern and a down-counting bit index.
module pat_shift_reg #(
    parameter int unsigned PAT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    output logic             msb,
    output logic             bit_zero
);
    localparam int unsigned BitCntW = $clog2(PAT_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(PAT_W - 1);

    logic [PAT_W-1:0]   shreg;
    logic [PAT_W-1:0]   held;
    logic [BitCntW-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg   <= '0;
            held    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= pattern;
            held    <= pattern;
            bit_cnt <= LastBit;
        end else if (reload) begin
            shreg   <= held;
            bit_cnt <= LastBit;
        end else if (shift) begin
            shreg   <= {shreg[PAT_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - BitCntW'(1);
        end
    end

    assign msb      = shreg[PAT_W-1];
    assign bit_zero = (bit_cnt == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, repeat_n+1 times, then pulses done.
// Define SEQ_PATTERN_TX_GAP_EN to insert one GAP cycle between repetitions.
module seq_pattern_tx
    import seq_fsm_pkg::*;
#(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    seq_pattern_tx_if.slave bus
);
    state_e           state;
    logic [CNT_W-1:0] rep_cnt;
    logic             load;
    logic             reload;
    logic             shift;
    logic             msb;
    logic             bit_zero;

    assign load   = (state == IDLE) && bus.start;
    assign reload = (state == SHIFT) && bit_zero && (rep_cnt != '0);
    assign shift  = (state == SHIFT) && !reload;

    pat_shift_reg #(
        .PAT_W(PAT_W)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .reload  (reload),
        .shift   (shift),
        .pattern (bus.pattern),
        .msb     (msb),
        .bit_zero(bit_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            rep_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        rep_cnt <= bus.repeat_n;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_zero) begin
                        if (rep_cnt == '0) begin
                            state <= DONE;
                        end else begin
                            rep_cnt <= rep_cnt - CNT_W'(1);
`ifdef SEQ_PATTERN_TX_GAP_EN
                            state   <= GAP;
`else
                            state   <= SHIFT;
`endif
                        end
                    end
                end
`ifdef SEQ_PATTERN_TX_GAP_EN
                GAP:  state <= SHIFT;
`else
                // Unreachable in this build; recover to IDLE if ever entered.
                GAP:  state <= IDLE;
`endif
                DONE: state <= IDLE;
            endcase
        end
    end

    assign bus.valid    = (state == SHIFT);
    assign bus.x_out    = (state == SHIFT) && msb;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.statereg = state;
endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 3, giving the pattern width in bits (minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the repeat count.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low. Port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: transmit request, sampled only in IDLE.
REQ-006 The block SHALL have port pattern, input, PAT_W bits: bits to transmit, MSB first, captured on accept.
REQ-007 The block SHALL have port repeat_n, input, CNT_W bits: extra repetitions (0 = send once), captured on accept.
REQ-008 The block SHALL have port x_out, output, 1 bit: serial data bit.
REQ-009 The block SHALL have port valid, output, 1 bit: x_out carries a pattern bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final bit.
REQ-012 The block SHALL have port statereg, output, 2 bits: current FSM state, for debug.

Function
REQ-013 The FSM SHALL be Moore, with states IDLE=2'b00, SHIFT=2'b01, GAP=2'b10 and DONE=2'b11; outputs depend only on registered state and datapath.
REQ-014 In IDLE with start=1, the block SHALL accept at that edge: capture pattern into both the shift register and a held copy, load repeat_n into the repeat counter, set the bit counter to PAT_W-1, and move to SHIFT.
REQ-015 In SHIFT, the block SHALL drive valid=1 and x_out=shift-register MSB; each edge shifts left by one and decrements the bit counter.
REQ-016 At the SHIFT edge where the bit counter is 0 and the repeat counter is 0, the block SHALL move to DONE.
REQ-017 At the SHIFT edge where the bit counter is 0 and the repeat counter is nonzero, the block SHALL decrement the repeat counter, reload the shift register from the held copy, reset the bit counter to PAT_W-1, and go to SHIFT, or to GAP when REQ-026 applies.
REQ-018 In DONE, the block SHALL drive done=1 for exactly one cycle, then return to IDLE unconditionally; start in DONE is ignored.
REQ-019 Outside SHIFT, the block SHALL hold x_out=0 and valid=0.
REQ-020 Latency: start accepted at edge t SHALL give the first valid bit in cycle t+1, PAT_W*(repeat_n+1) valid cycles without gaps, and done one cycle after the last bit.
REQ-021 While busy, the block SHALL ignore start and changes on pattern or repeat_n; start held high SHALL begin a new frame only from the IDLE cycle after DONE.
REQ-022 The repeat counter SHALL never wrap; repeat_n = 2^CNT_W-1 SHALL give 2^CNT_W repetitions.

Reset
REQ-023 With reset_n=0 at a rising edge, the block SHALL force state to IDLE and clear the shift register, held copy and both counters, regardless of start.
REQ-024 After reset, the block SHALL drive statereg=00, x_out=0, valid=0, busy=0 and done=0.
REQ-025 Reset mid-frame SHALL abort the frame with no done pulse; the next frame needs a fresh start.

Configuration
REQ-026 With macro SEQ_PATTERN_TX_GAP_EN defined, the block SHALL insert exactly one GAP cycle (valid=0, x_out=0, busy=1) between repetitions, then go to SHIFT; there is no GAP after the last repetition.
REQ-027 Without SEQ_PATTERN_TX_GAP_EN, GAP SHALL be unreachable and repetitions back-to-back; the GAP encoding, if ever entered, SHALL return to IDLE next cycle.

Structure
REQ-028 The state localparams/typedef (IDLE, SHIFT, GAP, DONE) SHALL reside in shared package seq_fsm_pkg, reusable by the sequence detectors.
REQ-029 The loadable shift register plus bit counter SHALL be one sub-module, pat_shift_reg; the FSM and repeat counter stay in the top.

Verification
REQ-030 Reset: reset_n=0 for 2 cycles with start=1 -> statereg=00, busy=0, valid=0, x_out=0, done=0.
REQ-031 Single frame: pattern=3'b010, repeat_n=0, one-cycle start -> valid 3 cycles, x_out 0,1,0; done in cycle 4; IDLE in cycle 5.
REQ-032 Repeat: pattern=3'b010, repeat_n=2 -> without macro, 9 contiguous bits 010010010 then done; with macro, 11 cycles with valid low in cycles 4 and 8.
REQ-033 Busy protection: start held high, pattern changed to 3'b111 during the 2nd bit -> frame stays 010; next frame sends 111 after the IDLE cycle.
REQ-034 Mid-frame reset: reset_n=0 during the 2nd bit -> IDLE at that edge, all outputs 0, no done pulse.
REQ-035 Max repeat: PAT_W=3, repeat_n=4'hF -> exactly 48 valid bits, single done pulse.
